led_mode_sequencer: RTL and testbench

- Sequences the 16-bit LED bank from the 16 board switches and one mode button.
- Four display modes, cycled by the button:
  - MIRROR: switches driven straight to the LEDs.
  - BLINK: switch pattern gated by a blink phase.
  - CHASE: one lit LED rotating around the bank.
  - COUNT: free-running binary counter.
- Sits directly between the board pins (SW, BTNC) and LED.
- Owns synchronisation, debounce, tick timing and the mode state machine.

---
 rtl/led_seq_pkg.sv | 30 +++
 rtl/led_mode_sequencer_btn_debounce.sv | 49 ++++
 rtl/led_mode_sequencer.sv | 97 +++++++++
 tb/tb_led_mode_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED mode sequencer.
package led_seq_pkg;

    localparam int LED_W = 16;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_e;

    localparam logic [LED_W-1:0] CHASE_INIT = 16'h0001;

    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_MIRROR: return MODE_BLINK;
            MODE_BLINK:  return MODE_CHASE;
            MODE_CHASE:  return MODE_COUNT;
            default:     return MODE_MIRROR;
        endcase
    endfunction

    // right=0 moves the lit bit toward the MSB, right=1 toward the LSB.
    function automatic logic [LED_W-1:0] chase_step(input logic [LED_W-1:0] v,
                                                    input logic right);
        return right ? {v[0], v[LED_W-1:1]} : {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/led_mode_sequencer_btn_debounce.sv
// Button conditioning: 2-flop sync, stable-count filter, rising-edge pulse.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    vld_pipe;
    logic [CW-1:0] cnt;
    logic          level, level_d, armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            vld_pipe <= '0;
            cnt      <= '0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync     <= {sync[0], btn};
            vld_pipe <= {vld_pipe[0], 1'b1};
            level_d  <= level;
            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            // Only arm once the real pin has been seen released, so a button
            // held through reset cannot produce a mode advance.
            if (vld_pipe[1] && !sync[1] && !level)
                armed <= 1'b1;
        end
    end

    assign rise = level & ~level_d & armed;

endmodule

// File: rtl/led_mode_sequencer.sv
// LED bank sequencer: switch sync, display tick, mode FSM and registered LED mux.
module led_mode_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic [LED_W-1:0] SW,
    input  logic             BTNC,
    output logic [LED_W-1:0] LED,
    output logic [1:0]       MODE
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [1:0][LED_W-1:0] sw_sync;
    logic [LED_W-1:0]      sw_s, chase_q, count_q, led_d;
    logic [TW-1:0]         tick_cnt;
    logic                  tick, phase, btn_rise, restart;
    mode_e                 mode_q, mode_d;

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) sw_sync <= '0;
        else     sw_sync <= {sw_sync[0], SW};
    end

    assign sw_s = sw_sync[1];

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk  (CLK100MHZ),
        .rst  (RST),
        .btn  (BTNC),
        .rise (btn_rise)
    );

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) mode_q <= MODE_MIRROR;
        else     mode_q <= mode_d;
    end

    always_comb begin
        mode_d  = mode_q;
        restart = 1'b0;
        if (btn_rise) begin
            mode_d  = next_mode(mode_q);
            restart = 1'b1;
        end
    end

    // A restart takes priority over a coincident tick, which is dropped.
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            chase_q  <= CHASE_INIT;
            count_q  <= '0;
        end else if (restart) begin
            tick_cnt <= '0;
            phase    <= 1'b0;
            chase_q  <= CHASE_INIT;
            count_q  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                case (mode_q)
                    MODE_BLINK: phase   <= ~phase;
                    MODE_CHASE: chase_q <= chase_step(chase_q, sw_s[0]);
                    MODE_COUNT: count_q <= count_q + LED_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_q)
            MODE_MIRROR: led_d = sw_s;
            MODE_BLINK:  led_d = phase ? sw_s : '0;
            MODE_CHASE:  led_d = chase_q;
            MODE_COUNT:  led_d = count_q;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) LED <= '0;
        else     LED <= led_d;
    end

    assign MODE = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer with short tick/debounce periods.
module tb_led_mode_sequencer;
    localparam int TICK_DIV  = 4;
    localparam int DEB       = 3;
    // pin -> 2 sync stages -> DEB stable cycles -> rise pulse -> mode edge
    localparam int PRESS_LAT = DEB + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic [15:0] sw  = 16'h0000;
    logic [15:0] led;
    logic [1:0]  mode;

    int tests_run    = 0;
    int tests_failed = 0;

    led_mode_sequencer #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
        .CLK100MHZ (clk),
        .RST       (rst),
        .SW        (sw),
        .BTNC      (btn),
        .LED       (led),
        .MODE      (mode)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);
    endtask

    // Press and hold until the mode edge; returns 1 ns after that edge, button released.
    task automatic enter_next(input int old);
        btn = 1'b1;
        step(PRESS_LAT - 1);
        tests_run++;
        if (mode !== 2'(old)) begin
            tests_failed++;
            $display("FAIL mode_early: got %0d want %0d", mode, old);
        end
        step(1);
        tests_run++;
        if (mode !== 2'((old + 1) % 4)) begin
            tests_failed++;
            $display("FAIL mode_adv: got %0d want %0d", mode, (old + 1) % 4);
        end
        btn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 16'hA5C3;
        step(3);
        tests_run++;
        if (led !== 16'h0000 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: led=%h mode=%0d want 0000/0", led, mode);
        end
        rst = 1'b0;
        step(2);
        tests_run++;
        if (led !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mirror_early: led=%h want 0000", led);
        end
        step(1);
        tests_run++;
        if (led !== 16'hA5C3 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL mirror_first: led=%h mode=%0d want a5c3/0", led, mode);
        end
    endtask

    task automatic test_mirror();
        logic [15:0] prev, nxt;
        for (int i = 0; i < 4; i++) begin
            prev = sw;
            nxt  = 16'($urandom);
            sw   = nxt;
            step(2);
            tests_run++;
            if (led !== prev) begin
                tests_failed++;
                $display("FAIL mirror_hold: led=%h want %h", led, prev);
            end
            step(1);
            tests_run++;
            if (led !== nxt) begin
                tests_failed++;
                $display("FAIL mirror_lat: led=%h want %h", led, nxt);
            end
        end
    endtask

    task automatic test_debounce();
        int g;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            g = (i < 2) ? i + 1 : int'($urandom_range(1, DEB - 1));
            btn = 1'b1;
            step(g);
            btn = 1'b0;
            step(12);
            tests_run++;
            if (mode !== 2'd0) begin
                tests_failed++;
                $display("FAIL glitch_%0d: mode=%0d want 0", g, mode);
            end
        end
        enter_next(0);
        btn = 1'b1;
        step(4 + 20);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL hold_once: mode=%0d want 1", mode);
        end
        btn = 1'b0;
        step(12);
        tests_run++;
        if (mode !== 2'd1) begin
            tests_failed++;
            $display("FAIL release_noop: mode=%0d want 1", mode);
        end
    endtask

    task automatic test_blink();
        logic [15:0] exp;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            sw = (it == 0) ? 16'h00FF : 16'($urandom);
            step(int'($urandom_range(0, 3)));
            enter_next(0);
            for (int k = 1; k <= 20; k++) begin
                step(1);
                exp = (((k - 1) / TICK_DIV) % 2 == 1) ? sw : 16'h0000;
                tests_run++;
                if (led !== exp || mode !== 2'd1) begin
                    tests_failed++;
                    $display("FAIL blink k=%0d: led=%h mode=%0d want %h/1", k, led, mode, exp);
                end
            end
        end
    endtask

    task automatic test_chase();
        logic [15:0] exp;
        int p, t;
        do_reset();
        sw = 16'($urandom) & 16'hFFFE;
        step(int'($urandom_range(0, 3)));
        enter_next(0);
        step(8);
        enter_next(1);
        for (int k = 1; k <= 100; k++) begin
            step(1);
            t = (k - 1) / TICK_DIV;
            // left for the first 16 ticks, right after the flip at k=64
            p = (t <= 16) ? t : 32 - t;
            exp = 16'h0001 << (((p % 16) + 16) % 16);
            tests_run++;
            if (led !== exp) begin
                tests_failed++;
                $display("FAIL chase k=%0d: led=%h want %h", k, led, exp);
            end
            if (k == 64) sw = sw | 16'h0001;
        end
    endtask

    task automatic test_count();
        logic [15:0] exp;
        do_reset();
        sw = 16'($urandom);
        enter_next(0);
        step(8);
        enter_next(1);
        step(8);
        enter_next(2);
        for (int k = 1; k <= 2; k++) begin
            step(1);
            tests_run++;
            if (led !== 16'h0000) begin
                tests_failed++;
                $display("FAIL count_start k=%0d: led=%h want 0000", k, led);
            end
        end
        force dut.count_q = 16'hFFFD;
        #2;
        release dut.count_q;
        for (int k = 3; k <= 20; k++) begin
            step(1);
            exp = 16'(32'hFFFD + (k - 1) / TICK_DIV);
            tests_run++;
            if (led !== exp) begin
                tests_failed++;
                $display("FAIL count k=%0d: led=%h want %h", k, led, exp);
            end
        end
        step(8);
        enter_next(3);
        step(1);
        tests_run++;
        if (led !== sw) begin
            tests_failed++;
            $display("FAIL wrap_mirror: led=%h want %h", led, sw);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp;
        do_reset();
        sw = 16'($urandom) & 16'hFFFE;
        enter_next(0);
        // press at k=6 lands the mode edge on k=12, a tick edge
        step(6);
        enter_next(1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            exp = 16'h0001 << ((k - 1) / TICK_DIV);
            tests_run++;
            if (led !== exp) begin
                tests_failed++;
                $display("FAIL sim_chase k=%0d: led=%h want %h", k, led, exp);
            end
        end
        enter_next(2);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp = 16'((k - 1) / TICK_DIV);
            tests_run++;
            if (led !== exp) begin
                tests_failed++;
                $display("FAIL sim_count k=%0d: led=%h want %h", k, led, exp);
            end
        end
        rst = 1'b1;
        #2;
        tests_run++;
        if (led !== 16'h0000 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL async_reset: led=%h mode=%0d want 0000/0", led, mode);
        end
        step(2);
        tests_run++;
        if (led !== 16'h0000 || mode !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_hold: led=%h mode=%0d want 0000/0", led, mode);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mirror();
        test_debounce();
        test_blink();
        test_chase();
        test_count();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
